mcu_exec_unit: RTL and testbench
================================

MCU_EXEC_UNIT -- requirements
Module: mcu_exec_unit

Interface
REQ-001 Parameter DATA_W, default 16, accumulator, memory and stack data width (>=8).
REQ-002 Parameter ADDR_W, default 12, data-memory and branch address width (>=8); instruction width IW = 4+ADDR_W.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid / instr_ready  input / output  1 / 1  instruction handshake; instr  input  IW, opcode instr[IW-1:IW-4], address instr[ADDR_W-1:0], ALU sub-op instr[ADDR_W-1:ADDR_W-4].
REQ-006 dmem_req, dmem_we  output  1 each  memory request, write enable; dmem_addr  output  ADDR_W; dmem_wdata  output  DATA_W; dmem_rdata  input  DATA_W; dmem_ack  input  1  completes request.
REQ-007 stack_to_a  input  DATA_W  pop data; a_to_stack  output  DATA_W  push data.
REQ-008 pc_branch  output  ADDR_W  JMP/JSR target; ctrl  output  4  sequencer code; ctrl_valid  output  1  one-cycle strobe qualifying ctrl.
REQ-009 acc_a, acc_b  output  DATA_W  registers A, B; flag_c, flag_z, int_en, halted  output  1 each.

Function
REQ-010 Opcodes SHALL be: LDA 0, LDB 1, STA 2, STB 3, JMP 4, HALT 5, ALU group 7, JSR 8, PUSHA A, POPA C, RET E; any other opcode is a NOP.
REQ-011 ALU sub-ops SHALL be: ADD 1, AND 2, CLA 3, CLB 4, CMB 5, INCB 6, DECB 7, CLC 8, CLZ 9, ION A, IOF B, SC C, SZ D; others NOP.
REQ-012 ctrl codes SHALL be: JMP 0000, JSR 0001, PUSH 0010, POP 0011, RET 0100, skip-on-C 0101, skip-on-Z 0110, ION 0111, IOF 1000, HALT 1001, increment-PC 1111.
REQ-013 FSM states IDLE, EXEC, MEM, HALT; instr_ready=1 only in IDLE; instr captured on instr_valid&&instr_ready, next state EXEC.
REQ-014 EXEC, non-memory op: register/flag update and ctrl_valid=1 with ctrl in that cycle, next state IDLE (accept-to-strobe latency 1 cycle).
REQ-015 EXEC, LDA/LDB/STA/STB: next state MEM; in MEM dmem_req=1, dmem_addr=address, dmem_we=1 for stores, dmem_wdata=A (STA) or B (STB), all stable until dmem_ack.
REQ-016 MEM with dmem_ack: loads latch dmem_rdata into A/B, ctrl_valid=1 ctrl=1111, next IDLE; ack in same cycle as MEM entry SHALL complete; dmem_ack outside MEM ignored.
REQ-017 JMP/JSR drive pc_branch=address; PUSHA drives a_to_stack=A; POPA loads A from stack_to_a in EXEC; pc_branch and a_to_stack hold until next such instruction.
REQ-018 ADD: {C,A} = A+B with DATA_W+1-bit sum, C=carry out; AND: A=A&B; CMB/INCB/DECB act on B modulo 2^DATA_W (FFFF+1=0000, 0000-1=FFFF at DATA_W=16).
REQ-019 Z SHALL update to (result==0) on ADD, AND, CMB, INCB, DECB only; CLC clears C; CLZ clears Z; CLA/CLB clear A/B without touching flags; all other ops leave flags unchanged.
REQ-020 SC: ctrl=0101 if C=1 else 1111; SZ: ctrl=0110 if Z=1 else 1111; neither changes flags.
REQ-021 ION sets int_en, IOF clears it, codes 0111/1000.
REQ-022 HALT: ctrl_valid with 1001, then state HALT, halted=1, instr_ready=0 until reset.
REQ-023 NOP opcodes: ctrl=1111, no state change.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, A, B, C, Z, int_en, halted, pc_branch, a_to_stack, ctrl=0, ctrl_valid=0, dmem_req=0, dmem_we=0; instr_ready=1 after release.
REQ-025 Reset during MEM SHALL abandon the access with no register update; a late dmem_ack is ignored.

Structure
REQ-026 Package mcu_pkg SHALL hold opcode, ALU sub-op and ctrl-code constants and the FSM state type.
REQ-027 One combinational sub-module mcu_alu SHALL compute A/B results and C/Z from sub-op, A, B, current flags.

Verification
REQ-028 Reset, then ADD with A=FFFF, B=0001 -> A=0000, C=1, Z=1, ctrl=1111 strobe one cycle after accept.
REQ-029 LDA 0x100 with dmem_ack delayed 3 cycles, rdata=ABCD -> dmem_req high 3 cycles, addr 0x100, A=ABCD, strobe cycle after ack.
REQ-030 SC with C=0 -> ctrl=1111; CLC after carry, then SC -> 0101 never, ctrl=1111; SZ after DECB from 0001 -> 0110.
REQ-031 JSR 0x2A5 -> pc_branch=2A5, ctrl=0001; PUSHA A=1234 -> a_to_stack=1234, ctrl=0010; POPA stack_to_a=5555 -> A=5555.
REQ-032 rst_n low mid-MEM STB -> dmem_req low asynchronously, later ack ignored, B unchanged at 0.
REQ-033 HALT then instr_valid held high -> ctrl=1001 once, halted=1, instr_ready stays 0; repeat at DATA_W=32, ADDR_W=16 for INCB wrap FFFFFFFF->0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared constants and types for the MCU execution unit: opcodes, ALU sub-ops,
// sequencer control codes and the FSM state type.
package mcu_pkg;

  localparam logic [3:0] OpLda   = 4'h0;
  localparam logic [3:0] OpLdb   = 4'h1;
  localparam logic [3:0] OpSta   = 4'h2;
  localparam logic [3:0] OpStb   = 4'h3;
  localparam logic [3:0] OpJmp   = 4'h4;
  localparam logic [3:0] OpHalt  = 4'h5;
  localparam logic [3:0] OpAlu   = 4'h7;
  localparam logic [3:0] OpJsr   = 4'h8;
  localparam logic [3:0] OpPusha = 4'hA;
  localparam logic [3:0] OpPopa  = 4'hC;
  localparam logic [3:0] OpRet   = 4'hE;

  localparam logic [3:0] AluAdd  = 4'h1;
  localparam logic [3:0] AluAnd  = 4'h2;
  localparam logic [3:0] AluCla  = 4'h3;
  localparam logic [3:0] AluClb  = 4'h4;
  localparam logic [3:0] AluCmb  = 4'h5;
  localparam logic [3:0] AluIncb = 4'h6;
  localparam logic [3:0] AluDecb = 4'h7;
  localparam logic [3:0] AluClc  = 4'h8;
  localparam logic [3:0] AluClz  = 4'h9;
  localparam logic [3:0] AluIon  = 4'hA;
  localparam logic [3:0] AluIof  = 4'hB;
  localparam logic [3:0] AluSc   = 4'hC;
  localparam logic [3:0] AluSz   = 4'hD;

  localparam logic [3:0] CtrlJmp   = 4'b0000;
  localparam logic [3:0] CtrlJsr   = 4'b0001;
  localparam logic [3:0] CtrlPush  = 4'b0010;
  localparam logic [3:0] CtrlPop   = 4'b0011;
  localparam logic [3:0] CtrlRet   = 4'b0100;
  localparam logic [3:0] CtrlSkipC = 4'b0101;
  localparam logic [3:0] CtrlSkipZ = 4'b0110;
  localparam logic [3:0] CtrlIon   = 4'b0111;
  localparam logic [3:0] CtrlIof   = 4'b1000;
  localparam logic [3:0] CtrlHalt  = 4'b1001;
  localparam logic [3:0] CtrlIncPc = 4'b1111;

  typedef enum logic [1:0] {StIdle, StExec, StMem, StHalt} state_e;

  // LDA/LDB/STA/STB occupy opcodes 0..3
  function automatic logic is_mem_op(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

  function automatic logic [3:0] ctrl_code(input logic [3:0] op, input logic [3:0] sub,
                                           input logic c, input logic z);
    logic [3:0] code;
    code = CtrlIncPc;
    case (op)
      OpJmp:   code = CtrlJmp;
      OpJsr:   code = CtrlJsr;
      OpPusha: code = CtrlPush;
      OpPopa:  code = CtrlPop;
      OpRet:   code = CtrlRet;
      OpHalt:  code = CtrlHalt;
      OpAlu: begin
        case (sub)
          AluIon:  code = CtrlIon;
          AluIof:  code = CtrlIof;
          AluSc:   code = c ? CtrlSkipC : CtrlIncPc;
          AluSz:   code = z ? CtrlSkipZ : CtrlIncPc;
          default: ;
        endcase
      end
      default: ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU: next A/B values and C/Z flags for one ALU sub-op.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [3:0]        sub_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c,
  input  logic              z,
  output logic [DATA_W-1:0] a_nxt,
  output logic [DATA_W-1:0] b_nxt,
  output logic              c_nxt,
  output logic              z_nxt
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] and_r;
  logic [DATA_W-1:0] cmb_r;
  logic [DATA_W-1:0] inc_r;
  logic [DATA_W-1:0] dec_r;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    and_r = a & b;
    cmb_r = ~b;
    inc_r = b + DATA_W'(1);
    dec_r = b - DATA_W'(1);
    a_nxt = a;
    b_nxt = b;
    c_nxt = c;
    z_nxt = z;
    case (sub_op)
      AluAdd: begin
        a_nxt = sum[DATA_W-1:0];
        c_nxt = sum[DATA_W];
        z_nxt = (sum[DATA_W-1:0] == '0);
      end
      AluAnd: begin
        a_nxt = and_r;
        z_nxt = (and_r == '0);
      end
      AluCla: a_nxt = '0;
      AluClb: b_nxt = '0;
      AluCmb: begin
        b_nxt = cmb_r;
        z_nxt = (cmb_r == '0);
      end
      AluIncb: begin
        b_nxt = inc_r;
        z_nxt = (inc_r == '0);
      end
      AluDecb: begin
        b_nxt = dec_r;
        z_nxt = (dec_r == '0);
      end
      AluClc:  c_nxt = 1'b0;
      AluClz:  z_nxt = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu_exec_unit.sv
// MCU execution unit: accepts one instruction at a time, updates A/B/flags,
// performs data-memory accesses and emits a one-cycle sequencer control strobe.
module mcu_exec_unit
  import mcu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  localparam int unsigned IW    = 4 + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [IW-1:0]     instr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] stack_to_a,
  output logic [DATA_W-1:0] a_to_stack,
  output logic [ADDR_W-1:0] pc_branch,
  output logic [3:0]        ctrl,
  output logic              ctrl_valid,
  output logic [DATA_W-1:0] acc_a,
  output logic [DATA_W-1:0] acc_b,
  output logic              flag_c,
  output logic              flag_z,
  output logic              int_en,
  output logic              halted
);

  state_e            state_q;
  logic [IW-1:0]     instr_q;
  logic [DATA_W-1:0] acc_a_q, acc_b_q, a_to_stack_q;
  logic [ADDR_W-1:0] pc_branch_q;
  logic              flag_c_q, flag_z_q, int_en_q, halted_q;
  logic [3:0]        ctrl_q;
  logic              ctrl_valid_q;

  logic [3:0]        op, sub, in_op, in_sub;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic              alu_c, alu_z;

  assign op     = instr_q[IW-1:IW-4];
  assign sub    = instr_q[ADDR_W-1:ADDR_W-4];
  assign addr   = instr_q[ADDR_W-1:0];
  assign in_op  = instr[IW-1:IW-4];
  assign in_sub = instr[ADDR_W-1:ADDR_W-4];

  mcu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .sub_op (sub),
    .a      (acc_a_q),
    .b      (acc_b_q),
    .c      (flag_c_q),
    .z      (flag_z_q),
    .a_nxt  (alu_a),
    .b_nxt  (alu_b),
    .c_nxt  (alu_c),
    .z_nxt  (alu_z)
  );

  // The strobe is registered at accept time so it is visible during EXEC; flags are
  // already final then because the previous instruction retired before IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      a_to_stack_q <= '0;
      pc_branch_q  <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      int_en_q     <= 1'b0;
      halted_q     <= 1'b0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
    end else begin
      ctrl_valid_q <= 1'b0;
      ctrl_q       <= '0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= StExec;
            if (!is_mem_op(in_op)) begin
              ctrl_valid_q <= 1'b1;
              ctrl_q       <= ctrl_code(in_op, in_sub, flag_c_q, flag_z_q);
            end
          end
        end
        StExec: begin
          if (is_mem_op(op)) begin
            state_q <= StMem;
          end else if (op == OpHalt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
          case (op)
            OpJmp, OpJsr: pc_branch_q  <= addr;
            OpPusha:      a_to_stack_q <= acc_a_q;
            OpPopa:       acc_a_q      <= stack_to_a;
            OpAlu: begin
              acc_a_q  <= alu_a;
              acc_b_q  <= alu_b;
              flag_c_q <= alu_c;
              flag_z_q <= alu_z;
              if (sub == AluIon) begin
                int_en_q <= 1'b1;
              end else if (sub == AluIof) begin
                int_en_q <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        StMem: begin
          if (dmem_ack) begin
            if (op == OpLda) acc_a_q <= dmem_rdata;
            if (op == OpLdb) acc_b_q <= dmem_rdata;
            ctrl_valid_q <= 1'b1;
            ctrl_q       <= CtrlIncPc;
            state_q      <= StIdle;
          end
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory strobes decode the state register so reset drops them immediately.
  assign instr_ready = (state_q == StIdle);
  assign dmem_req    = (state_q == StMem);
  assign dmem_we     = dmem_req && (op == OpSta || op == OpStb);
  assign dmem_addr   = addr;
  assign dmem_wdata  = (op == OpStb) ? acc_b_q : acc_a_q;

  assign a_to_stack = a_to_stack_q;
  assign pc_branch  = pc_branch_q;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = ctrl_valid_q;
  assign acc_a      = acc_a_q;
  assign acc_b      = acc_b_q;
  assign flag_c     = flag_c_q;
  assign flag_z     = flag_z_q;
  assign int_en     = int_en_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_mcu_exec_unit.sv
// Randomized bench for mcu_exec_unit: a transaction-level model predicts every
// output each cycle; directed sequences pin the model with literal values.
module tb_mcu_exec_unit;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          instr_valid, instr_ready, dmem_req, dmem_we, dmem_ack;
  logic [IW-1:0] instr;
  logic [AW-1:0] dmem_addr, pc_branch;
  logic [DW-1:0] dmem_wdata, dmem_rdata, stack_to_a, a_to_stack, acc_a, acc_b;
  logic [3:0]    ctrl;
  logic          ctrl_valid, flag_c, flag_z, int_en, halted;

  mcu_exec_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stack_to_a(stack_to_a), .a_to_stack(a_to_stack), .pc_branch(pc_branch), .ctrl(ctrl),
    .ctrl_valid(ctrl_valid), .acc_a(acc_a), .acc_b(acc_b), .flag_c(flag_c),
    .flag_z(flag_z), .int_en(int_en), .halted(halted)
  );

  // Wide instance for the 32-bit wrap and halt checks.
  logic        v2, r2, req2, we2, cv2, c2, z2, ie2, h2;
  logic [19:0] i2;
  logic [15:0] addr2, pc2;
  logic [31:0] wd2, ats2, a2, b2;
  logic [3:0]  ctrl2;

  mcu_exec_unit #(.DATA_W(32), .ADDR_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v2), .instr_ready(r2), .instr(i2),
    .dmem_req(req2), .dmem_we(we2), .dmem_addr(addr2), .dmem_wdata(wd2),
    .dmem_rdata(32'h0), .dmem_ack(1'b0), .stack_to_a(32'h0), .a_to_stack(ats2),
    .pc_branch(pc2), .ctrl(ctrl2), .ctrl_valid(cv2), .acc_a(a2), .acc_b(b2), .flag_c(c2),
    .flag_z(z2), .int_en(ie2), .halted(h2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state and per-cycle expectations
  logic [DW-1:0] m_a, m_b, m_ats;
  logic [AW-1:0] m_pc;
  logic          m_c, m_z, m_ie, m_halt;
  logic          exp_ready, exp_cv, exp_req, exp_we;
  logic [3:0]    exp_ctrl;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          check_en = 1'b0;

  logic          seen_cv;
  logic [3:0]    seen_ctrl;
  int            req_cycles;

  always @(negedge clk) begin
    if (check_en) begin
      chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
      chk("ctrl_valid", 32'(ctrl_valid), 32'(exp_cv));
      chk("ctrl", 32'(ctrl), 32'(exp_ctrl));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      if (exp_req) chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
      if (exp_we) chk("dmem_wdata", 32'(dmem_wdata), 32'(exp_wdata));
      chk("acc_a", 32'(acc_a), 32'(m_a));
      chk("acc_b", 32'(acc_b), 32'(m_b));
      chk("flag_c", 32'(flag_c), 32'(m_c));
      chk("flag_z", 32'(flag_z), 32'(m_z));
      chk("int_en", 32'(int_en), 32'(m_ie));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("pc_branch", 32'(pc_branch), 32'(m_pc));
      chk("a_to_stack", 32'(a_to_stack), 32'(m_ats));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    instr_valid = 1'($urandom);
    instr       = IW'($urandom);
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_ats = '0; m_pc = '0;
    m_c = 1'b0; m_z = 1'b0; m_ie = 1'b0; m_halt = 1'b0;
    exp_ready = 1'b1; exp_cv = 1'b0; exp_ctrl = '0;
    exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
  endtask

  task automatic gap();
    instr_valid = 1'b0;
    dmem_ack    = 1'($urandom);
    tick();
    dmem_ack = 1'b0;
    exp_cv   = 1'b0;
    exp_ctrl = '0;
  endtask

  // Issue one instruction from IDLE and run it to completion.
  task automatic run(input logic [3:0] op, input logic [AW-1:0] adr, input int dly,
                     input logic [DW-1:0] rdata, input logic [DW-1:0] stk);
    logic [3:0]    sub, code;
    logic [DW:0]   s;
    logic [DW-1:0] na, nb, nats;
    logic [AW-1:0] npc;
    logic          nc, nz, nie;
    sub         = adr[AW-1:AW-4];
    instr_valid = 1'b1;
    instr       = {op, adr};
    stack_to_a  = stk;
    tick();
    seen_cv   = ctrl_valid;
    seen_ctrl = ctrl;
    junk();
    dmem_ack  = 1'($urandom);
    exp_ready = 1'b0;
    if (op <= 4'h3) begin
      exp_cv   = 1'b0;
      exp_ctrl = '0;
      tick();
      dmem_ack   = 1'b0;
      exp_req    = 1'b1;
      exp_we     = (op == 4'h2 || op == 4'h3);
      exp_addr   = adr;
      exp_wdata  = (op == 4'h3) ? m_b : m_a;
      req_cycles = 0;
      for (int k = 0; k <= dly; k++) begin
        junk();
        req_cycles += int'(dmem_req);
        dmem_ack   = (k == dly);
        dmem_rdata = (k == dly) ? rdata : DW'($urandom);
        tick();
      end
      seen_cv     = ctrl_valid;
      seen_ctrl   = ctrl;
      dmem_ack    = 1'b0;
      instr_valid = 1'b0;
      exp_req     = 1'b0;
      exp_we      = 1'b0;
      exp_ready   = 1'b1;
      exp_cv      = 1'b1;
      exp_ctrl    = 4'hF;
      if (op == 4'h0) m_a = rdata;
      if (op == 4'h1) m_b = rdata;
    end else begin
      na = m_a; nb = m_b; nc = m_c; nz = m_z; nie = m_ie; npc = m_pc; nats = m_ats;
      code = 4'hF;
      case (op)
        4'h4: begin npc = adr; code = 4'h0; end
        4'h8: begin npc = adr; code = 4'h1; end
        4'hA: begin nats = m_a; code = 4'h2; end
        4'hC: begin na = stk; code = 4'h3; end
        4'hE: code = 4'h4;
        4'h5: code = 4'h9;
        4'h7: begin
          case (sub)
            4'h1: begin
              s  = {1'b0, m_a} + {1'b0, m_b};
              na = s[DW-1:0];
              nc = s[DW];
              nz = (na == 0);
            end
            4'h2: begin na = m_a & m_b; nz = (na == 0); end
            4'h3: na = '0;
            4'h4: nb = '0;
            4'h5: begin nb = ~m_b; nz = (nb == 0); end
            4'h6: begin nb = m_b + 16'd1; nz = (nb == 0); end
            4'h7: begin nb = m_b - 16'd1; nz = (nb == 0); end
            4'h8: nc = 1'b0;
            4'h9: nz = 1'b0;
            4'hA: begin nie = 1'b1; code = 4'h7; end
            4'hB: begin nie = 1'b0; code = 4'h8; end
            4'hC: code = m_c ? 4'h5 : 4'hF;
            4'hD: code = m_z ? 4'h6 : 4'hF;
            default: ;
          endcase
        end
        default: ;
      endcase
      exp_cv   = 1'b1;
      exp_ctrl = code;
      tick();
      instr_valid = 1'b0;
      dmem_ack    = 1'b0;
      m_a = na; m_b = nb; m_c = nc; m_z = nz; m_ie = nie; m_pc = npc; m_ats = nats;
      if (op == 4'h5) m_halt = 1'b1;
      exp_cv    = 1'b0;
      exp_ctrl  = '0;
      exp_ready = (op != 4'h5);
    end
  endtask

  int strobes;

  initial begin
    instr_valid = 1'b0; instr = '0; dmem_ack = 1'b0; dmem_rdata = '0; stack_to_a = '0;
    v2 = 1'b0; i2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_acc_a", 32'(acc_a), 32'd0);
    chk("rst_acc_b", 32'(acc_b), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z, int_en, halted}), 32'd0);
    chk("rst_ctrl", 32'({ctrl_valid, ctrl}), 32'd0);
    chk("rst_dmem", 32'({dmem_req, dmem_we}), 32'd0);
    chk("rst_pc_ats", 32'({pc_branch, a_to_stack}), 32'd0);
    check_en = 1'b1;

    // ADD FFFF + 0001
    run(4'h0, 12'h010, 0, 16'hFFFF, 16'h0);
    run(4'h1, 12'h011, 1, 16'h0001, 16'h0);
    run(4'h7, 12'h100, 0, 16'h0, 16'h0);
    chk("add_strobe", 32'({seen_cv, seen_ctrl}), 32'h1F);
    chk("add_result", 32'({flag_c, flag_z, acc_a}), 32'h30000);

    // Skip-on-carry / skip-on-zero
    run(4'h7, 12'hC00, 0, 16'h0, 16'h0);
    chk("sc_c1", 32'({seen_cv, seen_ctrl}), 32'h15);
    run(4'h7, 12'h800, 0, 16'h0, 16'h0);
    run(4'h7, 12'hC00, 0, 16'h0, 16'h0);
    chk("sc_after_clc", 32'({seen_cv, seen_ctrl}), 32'h1F);
    run(4'h1, 12'h020, 0, 16'h0001, 16'h0);
    run(4'h7, 12'h700, 0, 16'h0, 16'h0);
    run(4'h7, 12'hD00, 0, 16'h0, 16'h0);
    chk("sz_after_decb", 32'({seen_cv, seen_ctrl}), 32'h16);

    // Delayed-ack load
    run(4'h0, 12'h100, 2, 16'hABCD, 16'h0);
    chk("lda_req_cycles", 32'(req_cycles), 32'd3);
    chk("lda_strobe", 32'({seen_cv, seen_ctrl}), 32'h1F);
    chk("lda_acc_a", 32'(acc_a), 32'hABCD);

    // JSR / PUSHA / POPA
    run(4'h8, 12'h2A5, 0, 16'h0, 16'h0);
    chk("jsr", 32'({seen_ctrl, pc_branch}), 32'h12A5);
    run(4'h0, 12'h030, 0, 16'h1234, 16'h0);
    run(4'hA, 12'h000, 0, 16'h0, 16'h0);
    chk("pusha", 32'({seen_ctrl, a_to_stack}), 32'h21234);
    run(4'hC, 12'h000, 0, 16'h0, 16'h5555);
    chk("popa", 32'({seen_ctrl, acc_a}), 32'h35555);

    // Randomized traffic, HALT excluded
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'h5) op = 4'h7;
      run(op, AW'($urandom), int'($urandom_range(0, 3)), DW'($urandom), DW'($urandom));
      if ($urandom_range(0, 3) == 0) gap();
    end

    // Reset in the middle of a store
    run(4'h7, 12'h400, 0, 16'h0, 16'h0);
    check_en    = 1'b0;
    instr_valid = 1'b1;
    instr       = 16'h3055;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("stb_req", 32'({dmem_req, dmem_we}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", 32'({dmem_req, dmem_we}), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 16'h7777;
    tick();
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_b", 32'(acc_b), 32'h0);
    chk("late_ack_state", 32'({instr_ready, dmem_req, ctrl_valid}), 32'h4);
    model_reset();
    check_en = 1'b1;

    // HALT with instr_valid held
    run(4'h5, 12'h000, 0, 16'h0, 16'h0);
    chk("halt_strobe", 32'({seen_cv, seen_ctrl}), 32'h19);
    instr_valid = 1'b1;
    instr       = 16'h7600;
    strobes     = 0;
    repeat (6) begin
      tick();
      strobes += int'(ctrl_valid);
    end
    chk("halt_no_more_strobes", 32'(strobes), 32'd0);
    chk("halt_state", 32'({halted, instr_ready}), 32'h2);
    instr_valid = 1'b0;

    // 32-bit instance: CMB then INCB wraps FFFFFFFF to 0, then HALT
    v2 = 1'b1; i2 = 20'h75000;
    tick();
    v2 = 1'b0;
    tick();
    chk("w32_cmb", b2, 32'hFFFF_FFFF);
    v2 = 1'b1; i2 = 20'h76000;
    tick();
    chk("w32_incb_strobe", 32'({cv2, ctrl2}), 32'h1F);
    v2 = 1'b0;
    tick();
    chk("w32_incb_wrap", b2, 32'h0);
    chk("w32_incb_z", 32'(z2), 32'd1);
    v2 = 1'b1; i2 = 20'h50000;
    tick();
    chk("w32_halt_strobe", 32'({cv2, ctrl2}), 32'h19);
    strobes = 0;
    repeat (5) begin
      tick();
      strobes += int'(cv2);
      chk("w32_halt_ready", 32'({h2, r2}), 32'h2);
    end
    chk("w32_halt_once", 32'(strobes), 32'd0);
    v2 = 1'b0;

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
